// File: rtl/cpu_writeback_multi.sv
// cpu_writeback_multi: multi-lane writeback stage.
// Detects completions via per-lane toggle strobes, counts retirements and
// serialises register writes from all lanes through a small FIFO onto the
// single register-file write port.
// Optional feature macro: CPU_WRITEBACK_BYPASS_EN (empty queue sends the
// lowest qualifying lane straight to the RF port, saving one cycle).
module cpu_writeback_multi #(
    parameter int LANES      = 2,
    parameter int XLEN       = 32,
    parameter int RIDX_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 64
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [LANES-1:0]          i_strobe,
    input  logic [LANES*RIDX_W-1:0]   i_rd_idx,
    input  logic [LANES*XLEN-1:0]     i_rd_val,
    output logic                      o_ready,
    output logic                      o_rf_we,
    output logic [RIDX_W-1:0]         o_rf_idx,
    output logic [XLEN-1:0]           o_rf_val,
    output logic [CNT_W-1:0]          o_retired,
    output logic                      o_overflow
);

    // Pointer width is at least 1 so a depth-1 queue still has a legal ring.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CQ_W  = PTR_W + 1;
    localparam int MEM_N = 1 << PTR_W;

    logic [LANES-1:0]   last_strobe;
    logic [LANES-1:0]   events;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CQ_W-1:0]    count;
    logic [RIDX_W-1:0]  mem_idx [MEM_N];
    logic [XLEN-1:0]    mem_val [MEM_N];

    logic               pop;
    logic [CQ_W-1:0]    free;
    logic [CQ_W-1:0]    n_push;
    logic [LANES-1:0]   enq;
    logic [PTR_W-1:0]   slot [LANES];
    logic               dropped;
    logic [CNT_W-1:0]   retire_inc;
`ifdef CPU_WRITEBACK_BYPASS_EN
    logic               byp_take;
    logic [RIDX_W-1:0]  byp_idx;
    logic [XLEN-1:0]    byp_val;
`endif

    // Queue occupancy view: pop happens whenever something was queued before this edge.
    always_comb begin
        events  = i_strobe ^ last_strobe;
        pop     = (count != '0);
        free    = CQ_W'(FIFO_DEPTH) - count + CQ_W'(pop);
        o_ready = (int'(free) >= LANES);
    end

    // Allocate queue slots to qualifying lanes in program order; overflow drops the tail lanes.
    always_comb begin
        n_push     = '0;
        enq        = '0;
        dropped    = 1'b0;
        retire_inc = '0;
`ifdef CPU_WRITEBACK_BYPASS_EN
        byp_take   = 1'b0;
        byp_idx    = '0;
        byp_val    = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            slot[k] = '0;
            if (events[k]) begin
                retire_inc = retire_inc + CNT_W'(1);
                if (i_rd_idx[k*RIDX_W +: RIDX_W] != '0) begin
`ifdef CPU_WRITEBACK_BYPASS_EN
                    if (count == '0 && !byp_take) begin
                        byp_take = 1'b1;
                        byp_idx  = i_rd_idx[k*RIDX_W +: RIDX_W];
                        byp_val  = i_rd_val[k*XLEN +: XLEN];
                    end else
`endif
                    if (n_push < free) begin
                        enq[k]  = 1'b1;
                        slot[k] = wr_ptr + n_push[PTR_W-1:0];
                        n_push  = n_push + CQ_W'(1);
                    end else begin
                        dropped = 1'b1;
                    end
                end
            end
        end
    end

    // Queue storage: data only, pointers make stale entries invisible after reset.
    always_ff @(posedge i_clock) begin
        for (int k = 0; k < LANES; k++) begin
            if (enq[k]) begin
                mem_idx[slot[k]] <= i_rd_idx[k*RIDX_W +: RIDX_W];
                mem_val[slot[k]] <= i_rd_val[k*XLEN +: XLEN];
            end
        end
    end

    // Control state, retire counter and the registered RF write port.
    always_ff @(posedge i_clock) begin
        last_strobe <= i_strobe;
        if (i_reset) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_retired  <= '0;
            o_overflow <= 1'b0;
            o_rf_we    <= 1'b0;
            o_rf_idx   <= '0;
            o_rf_val   <= '0;
        end else begin
            o_retired <= o_retired + retire_inc;
            if (dropped)
                o_overflow <= 1'b1;
            count  <= count + n_push - CQ_W'(pop);
            wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                o_rf_we  <= 1'b1;
                o_rf_idx <= mem_idx[rd_ptr];
                o_rf_val <= mem_val[rd_ptr];
            end
`ifdef CPU_WRITEBACK_BYPASS_EN
            else if (byp_take) begin
                o_rf_we  <= 1'b1;
                o_rf_idx <= byp_idx;
                o_rf_val <= byp_val;
            end
`endif
            else begin
                o_rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_writeback_multi.sv
// Bench for cpu_writeback_multi (LANES=2, FIFO_DEPTH=4): directed scenarios
// followed by randomized traffic, all checked against a queue-based model.
module tb_cpu_writeback_multi;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int RW    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = 64;

`ifdef CPU_WRITEBACK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clock = 1'b0;
    logic                  reset;
    logic [LANES-1:0]      strobe;
    logic [LANES*RW-1:0]   rd_idx;
    logic [LANES*XLEN-1:0] rd_val;
    logic                  ready, rf_we, overflow;
    logic [RW-1:0]         rf_idx;
    logic [XLEN-1:0]       rf_val;
    logic [CW-1:0]         retired;

    cpu_writeback_multi #(.LANES(LANES), .XLEN(XLEN), .RIDX_W(RW),
                          .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .i_clock(clock), .i_reset(reset), .i_strobe(strobe),
        .i_rd_idx(rd_idx), .i_rd_val(rd_val), .o_ready(ready),
        .o_rf_we(rf_we), .o_rf_idx(rf_idx), .o_rf_val(rf_val),
        .o_retired(retired), .o_overflow(overflow));

    always #5 clock = ~clock;

    typedef struct packed {
        logic [RW-1:0]   idx;
        logic [XLEN-1:0] val;
    } wr_t;

    // Reference model state
    wr_t              q[$];
    logic [CW-1:0]    m_ret;
    bit               m_ovf;
    bit               m_we;
    logic [RW-1:0]    m_idx;
    logic [XLEN-1:0]  m_val;
    logic [LANES-1:0] m_last;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the inputs already set for one edge, advance the model, compare all outputs.
    task automatic step();
        int  sz, free, acc;
        bit  popd, byp_used;
        wr_t w;
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_ret = '0; m_ovf = 0; m_we = 0; m_idx = '0; m_val = '0;
        end else begin
            sz   = q.size();
            popd = (sz > 0);
            free = DEPTH - sz + (popd ? 1 : 0);
            acc  = 0;
            byp_used = 0;
            m_we = 0;
            if (popd) begin
                w = q.pop_front();
                m_we = 1; m_idx = w.idx; m_val = w.val;
            end
            for (int k = 0; k < LANES; k++) begin
                if (strobe[k] != m_last[k]) begin
                    m_ret = m_ret + 1;
                    w.idx = rd_idx[k*RW +: RW];
                    w.val = rd_val[k*XLEN +: XLEN];
                    if (w.idx != 0) begin
                        if (BYP && sz == 0 && !byp_used) begin
                            byp_used = 1;
                            m_we = 1; m_idx = w.idx; m_val = w.val;
                        end else if (acc < free) begin
                            q.push_back(w);
                            acc++;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
            end
        end
        m_last = strobe;
        #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_idx", rf_idx, m_idx);
        chk("rf_val", rf_val, m_val);
        chk("retired", retired, m_ret);
        chk("overflow", overflow, m_ovf);
        chk("ready", ready, ((DEPTH - q.size() + (q.size() > 0 ? 1 : 0)) >= LANES));
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    // Toggle the lanes in mask with the given destinations/values for one edge.
    task automatic fire(input logic [1:0] mask, input logic [RW-1:0] i0, input logic [XLEN-1:0] v0,
                        input logic [RW-1:0] i1, input logic [XLEN-1:0] v1);
        rd_idx = {i1, i0};
        rd_val = {v1, v0};
        strobe = strobe ^ mask;
        step();
    endtask

    initial begin
        int n5;
        reset  = 1'b1;
        strobe = 2'b11;
        rd_idx = '0;
        rd_val = '0;
        m_last = 2'b11;

        // 1: reset with strobes high, then hold: nothing retires
        do_reset(2);
        idle(3);
        chk("t1_retired", retired, 64'd0);
        chk("t1_we", rf_we, 1'b0);

        // 2: single completion on lane 0
        fire(2'b01, 6'd5, 32'hDEADBEEF, 6'd0, 32'h0);
        chk("t2_we_edge0", rf_we, BYP);
        step();
        chk("t2_we_edge1", rf_we, !BYP);
        chk("t2_idx", rf_idx, 6'd5);
        chk("t2_val", rf_val, 32'hDEADBEEF);
        chk("t2_retired", retired, 64'd1);
        idle(2);

        // 3: both lanes, writes come out in lane order
        fire(2'b11, 6'd1, 32'h11, 6'd2, 32'h22);
        idle(3);
        chk("t3_retired", retired, 64'd3);

        // 4: rd_idx 0 retires but never writes
        fire(2'b01, 6'd0, 32'h99, 6'd0, 32'h0);
        chk("t4_we", rf_we, 1'b0);
        idle(2);
        chk("t4_retired", retired, 64'd4);

        // 5: both lanes every cycle until the queue overflows
        do_reset(1);
        n5 = BYP ? 6 : 4;
        for (int i = 0; i < n5; i++)
            fire(2'b11, RW'(10 + 2*i), $urandom, RW'(11 + 2*i), $urandom);
        chk("t5_overflow", overflow, 1'b1);
        chk("t5_retired", retired, 64'(2*n5));
        idle(6);
        chk("t5_sticky", overflow, 1'b1);

        // 6: reset while writes are queued discards them
        do_reset(1);
        fire(2'b11, 6'd3, 32'h33, 6'd4, 32'h44);
        fire(2'b01, 6'd7, 32'h77, 6'd0, 32'h0);
        do_reset(1);
        chk("t6_we", rf_we, 1'b0);
        chk("t6_retired", retired, 64'd0);
        idle(3);
        chk("t6_empty_we", rf_we, 1'b0);

        // Randomized traffic; mostly honours o_ready, occasionally overruns, one mid reset
        for (int i = 0; i < 400; i++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            if (!ready && $urandom_range(0, 7) != 0) m = 2'b00;
            if (i == 200) do_reset(1);
            fire(m, RW'($urandom_range(0, 7)), $urandom, RW'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
